// File: rtl/multi_debounce_pkg.sv
// rtl/multi_debounce_pkg.sv - shared width helper and default timing constants for multi_debounce
package multi_debounce_pkg;

  localparam int DEBOUNCE_TICK_DIV_25MHZ = 250;
  localparam int DEBOUNCE_STABLE_10MS    = 1000;

  // Counter width able to hold 0..value-1, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounce channel: synchroniser, stability counter, level and strobes
// Optional auto-repeat hold counter under MULTI_DEBOUNCE_REPEAT_EN.
module debounce_channel
  import multi_debounce_pkg::*;
#(
  parameter int   STABLE_TICKS = DEBOUNCE_STABLE_10MS,
  parameter logic INIT_LEVEL   = 1'b0
`ifdef MULTI_DEBOUNCE_REPEAT_EN
  ,
  parameter int   HOLD_TICKS   = 50000,
  parameter int   REPEAT_TICKS = 10000
`endif
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Tick,
  input  logic i_Raw,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall
`ifdef MULTI_DEBOUNCE_REPEAT_EN
  ,
  output logic o_Repeat
`endif
);

  localparam int CW = clog2_min1(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] stable_cnt;
  logic          sync_s;
  logic          flip;

  assign sync_s = sync_q[1];
  assign flip   = (sync_s != o_Level) && i_Tick && (stable_cnt == CNT_MAX);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_q     <= {2{INIT_LEVEL}};
      stable_cnt <= '0;
      o_Level    <= INIT_LEVEL;
      o_Rise     <= 1'b0;
      o_Fall     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_Raw};
      o_Rise <= 1'b0;
      o_Fall <= 1'b0;
      // Any sample matching the current level restarts qualification, tick or not.
      if (sync_s == o_Level) begin
        stable_cnt <= '0;
      end else if (flip) begin
        stable_cnt <= '0;
        o_Level    <= sync_s;
        o_Rise     <= sync_s;
        o_Fall     <= ~sync_s;
      end else if (i_Tick) begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

`ifdef MULTI_DEBOUNCE_REPEAT_EN
  localparam int HW = clog2_min1((HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] REPEAT_MAX = HW'(REPEAT_TICKS - 1);

  logic [HW-1:0] hold_cnt;
  logic          repeating;

  // repeating selects the shorter period once the first hold strobe has fired.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
      o_Repeat  <= 1'b0;
    end else begin
      o_Repeat <= 1'b0;
      if (flip || !o_Level) begin
        hold_cnt  <= '0;
        repeating <= 1'b0;
      end else if (i_Tick) begin
        if (hold_cnt == (repeating ? REPEAT_MAX : HOLD_MAX)) begin
          hold_cnt  <= '0;
          repeating <= 1'b1;
          o_Repeat  <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/multi_debounce.sv
// rtl/multi_debounce.sv - N-channel switch debouncer sharing one tick prescaler
// Optional auto-repeat output o_Repeat under MULTI_DEBOUNCE_REPEAT_EN.
module multi_debounce
  import multi_debounce_pkg::*;
#(
  parameter int   NUM_CH       = 4,
  parameter int   TICK_DIV     = DEBOUNCE_TICK_DIV_25MHZ,
  parameter int   STABLE_TICKS = DEBOUNCE_STABLE_10MS,
  parameter logic INIT_LEVEL   = 1'b0
`ifdef MULTI_DEBOUNCE_REPEAT_EN
  ,
  parameter int   HOLD_TICKS   = 50000,
  parameter int   REPEAT_TICKS = 10000
`endif
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Switches,
  output logic [NUM_CH-1:0] o_Switches,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall
`ifdef MULTI_DEBOUNCE_REPEAT_EN
  ,
  output logic [NUM_CH-1:0] o_Repeat
`endif
);

  localparam int PW = clog2_min1(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PRE_MAX);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .INIT_LEVEL   (INIT_LEVEL)
`ifdef MULTI_DEBOUNCE_REPEAT_EN
      ,
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
`endif
    ) u_channel (
      .i_Clk    (i_Clk),
      .i_Rst_L  (i_Rst_L),
      .i_Tick   (tick),
      .i_Raw    (i_Switches[ch]),
      .o_Level  (o_Switches[ch]),
      .o_Rise   (o_Rise[ch]),
      .o_Fall   (o_Fall[ch])
`ifdef MULTI_DEBOUNCE_REPEAT_EN
      ,
      .o_Repeat (o_Repeat[ch])
`endif
    );
  end

endmodule

// File: tb/tb_multi_debounce.sv
// tb/tb_multi_debounce.sv - directed self-checking bench for multi_debounce (4 ch, TICK_DIV=4, STABLE_TICKS=3)
// Repeat steps run when MULTI_DEBOUNCE_REPEAT_EN is defined.
module tb_multi_debounce;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L;
  logic [3:0] i_Switches;
  logic [3:0] o_Switches;
  logic [3:0] o_Rise;
  logic [3:0] o_Fall;
`ifdef MULTI_DEBOUNCE_REPEAT_EN
  logic [3:0] o_Repeat;
`endif

  int checks = 0;
  int errors = 0;

  multi_debounce #(
    .NUM_CH       (4),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .INIT_LEVEL   (1'b0)
`ifdef MULTI_DEBOUNCE_REPEAT_EN
    ,
    .HOLD_TICKS   (5),
    .REPEAT_TICKS (2)
`endif
  ) dut (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Switches (i_Switches),
    .o_Switches (o_Switches),
    .o_Rise     (o_Rise),
    .o_Fall     (o_Fall)
`ifdef MULTI_DEBOUNCE_REPEAT_EN
    ,
    .o_Repeat   (o_Repeat)
`endif
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int cnt;
    int bad;
    logic found;

    // Reset with all raw inputs high
    i_Rst_L    = 1'b0;
    i_Switches = 4'hF;
    repeat (3) @(negedge i_Clk);
    check("rst_switches", 32'(o_Switches), 32'h0);
    check("rst_rise", 32'(o_Rise), 32'h0);
    check("rst_fall", 32'(o_Fall), 32'h0);
`ifdef MULTI_DEBOUNCE_REPEAT_EN
    check("rst_repeat", 32'(o_Repeat), 32'h0);
`endif
    i_Switches = 4'h0;
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge i_Clk);
      if (o_Rise != 4'h0 || o_Fall != 4'h0 || o_Switches != 4'h0) bad++;
    end
    check("post_rst_quiet", 32'(bad), 32'h0);

    // Clean step on ch0
    i_Switches[0] = 1'b1;
    n = 0;
    found = 1'b0;
    for (int i = 1; i <= 30 && !found; i++) begin
      @(negedge i_Clk);
      if (o_Switches[0]) begin
        n = i;
        found = 1'b1;
      end
    end
    check("step_seen", 32'(found), 32'h1);
    check("step_latency_11_14", 32'((n >= 11) && (n <= 14)), 32'h1);
    check("step_rise", 32'(o_Rise), 32'h1);
    check("step_fall", 32'(o_Fall), 32'h0);
    @(negedge i_Clk);
    check("step_rise_one_cycle", 32'(o_Rise), 32'h0);

    // Bounce on ch1: toggles every 3 cycles never qualify
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) i_Switches[1] = ~i_Switches[1];
      @(negedge i_Clk);
      if (o_Switches[1] || o_Rise[1] || o_Fall[1]) bad++;
    end
    check("bounce_no_change", 32'(bad), 32'h0);
    i_Switches[1] = 1'b1;
    cnt = 0;
    repeat (25) begin
      @(negedge i_Clk);
      if (o_Rise[1]) cnt++;
    end
    check("bounce_single_rise", 32'(cnt), 32'h1);
    check("bounce_level", 32'(o_Switches), 32'h3);

    // Release ch0
    i_Switches[0] = 1'b0;
    cnt = 0;
    bad = 0;
    repeat (25) begin
      @(negedge i_Clk);
      if (o_Fall[0]) cnt++;
      if (o_Rise != 4'h0 || o_Fall[3:1] != 3'h0 || !o_Switches[1]) bad++;
    end
    check("release_single_fall", 32'(cnt), 32'h1);
    check("release_others_quiet", 32'(bad), 32'h0);
    check("release_level", 32'(o_Switches), 32'h2);

    // Simultaneous rise on all channels
    i_Switches = 4'h0;
    repeat (25) @(negedge i_Clk);
    check("simul_pre_clear", 32'(o_Switches), 32'h0);
    i_Switches = 4'hF;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge i_Clk);
      if (o_Switches != 4'h0) found = 1'b1;
    end
    check("simul_seen", 32'(found), 32'h1);
    check("simul_rise", 32'(o_Rise), 32'hF);
    check("simul_level", 32'(o_Switches), 32'hF);

    // Asynchronous reset mid-count, checked before the next rising edge
    i_Switches = 4'h0;
    repeat (5) @(negedge i_Clk);
    #1 i_Rst_L = 1'b0;
    #1;
    check("async_rst_switches", 32'(o_Switches), 32'h0);
    check("async_rst_strobes", 32'({o_Rise, o_Fall}), 32'h0);
    @(negedge i_Clk);
    i_Rst_L = 1'b1;

`ifdef MULTI_DEBOUNCE_REPEAT_EN
    // Hold ch2: first repeat 5 ticks (20 cycles) after level rises, then every 8 cycles
    i_Switches[2] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge i_Clk);
      if (o_Switches[2]) found = 1'b1;
    end
    check("rep_level_seen", 32'(found), 32'h1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      found = 1'b0;
      for (int i = 1; i <= 40 && !found; i++) begin
        @(negedge i_Clk);
        if (o_Repeat[2]) begin
          n = i;
          found = 1'b1;
        end
      end
      check("rep_gap", 32'(n), (k == 0) ? 32'd20 : 32'd8);
      check("rep_channel", 32'(o_Repeat), 32'h4);
    end
    i_Switches[2] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge i_Clk);
      if (!o_Switches[2]) found = 1'b1;
    end
    check("rep_release_seen", 32'(found), 32'h1);
    cnt = 0;
    repeat (30) begin
      @(negedge i_Clk);
      if (o_Repeat != 4'h0) cnt++;
    end
    check("rep_stops", 32'(cnt), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
